bus_interconnect_nxm: RTL and testbench
=======================================

// Module: bus_interconnect_nxm
// PURPOSE
//  Parametrised N-master x M-slave interconnect for the serial system bus; successor to the fixed 2x3 interconnect.
//  Contains a round-robin arbiter FSM with grant hold and slave-select validation, plus a routing mux driven by the latched grant and slave select.
//  Sits between master ports and slave ports at the top level. All logic runs in one clock domain.
// PARAMETERS
//  NUM_MASTERS     2   number of masters (>=2)
//  NUM_SLAVES      3   number of slaves (>=1)
//  SEL_W           2   slave-select width per master; must satisfy 2**SEL_W >= NUM_SLAVES
//  TIMEOUT_CYCLES  64  BUSY-state watchdog limit; used only with BUS_TIMEOUT_EN
// PORTS
//  sys_clk          in   1           system clock
//  sys_rst          in   1           synchronous, active-high reset
//  m_request        in   NM          per-master bus request
//  m_slave_sel      in   NM*SEL_W    per-master target slave index; master i uses [i*SEL_W +: SEL_W]
//  trans_done       in   1           current transfer complete (1-cycle pulse)
//  m_grant          out  NM          one-hot grant
//  arbiter_busy     out  1           high in ARB state
//  bus_busy         out  1           high in BUSY state
//  sel_err          out  1           1-cycle pulse: winner selected a nonexistent slave
//  bus_timeout      out  1           1-cycle pulse: watchdog abort
//  m_master_valid, m_master_ready, m_tx_address, m_tx_data, m_write_en, m_read_en   in   NM  master->bus signals
//  m_rx_data, m_slave_valid, m_slave_ready                                          out  NM  bus->master signals
//  s_master_valid, s_master_ready, s_rx_address, s_rx_data, s_write_en, s_read_en   out  NS  bus->slave signals
//  s_tx_data, s_slave_valid, s_slave_ready                                          in   NS  slave->bus signals
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; rr_ptr=NM-1, so master 0 has first priority.
//   All outputs 0 at the first edge with sys_rst high, including when reset arrives mid-BUSY.
//  FSM states:
//   IDLE: any m_request -> ARB. Otherwise stay.
//   ARB (1 cycle, arbiter_busy=1):
//    - Winner = first requester searching rr_ptr+1 upward, wrapping modulo NM.
//    - Latch winner index and its m_slave_sel.
//    - Valid sel (< NUM_SLAVES): rr_ptr <= winner; go to BUSY.
//    - Invalid sel: pulse sel_err; rr_ptr <= winner, so the winner does not win again immediately; no grant; return to IDLE.
//    - No requester remains at ARB: return to IDLE silently.
//   BUSY (bus_busy=1, m_grant[winner]=1): exit to IDLE on trans_done, or when m_request[winner] is sampled low.
//    - Grant drops on the edge following that sample.
//    - Every exit passes through IDLE, giving one idle cycle between consecutive grants.
//  Latency:
//   - Request sampled at edge k: ARB during cycle k+1, grant visible at k+2.
//   - Back-to-back transfers: trans_done at edge t, next grant at t+3.
//  Simultaneous events:
//   - trans_done and request drop together: single exit.
//   - A request raised while BUSY waits for IDLE/ARB.
//   - m_slave_sel changes during BUSY are ignored; the latched value holds.
//  Mux (combinational from latched winner/sel, valid only in BUSY):
//   - Selected slave's s_* outputs follow the winner's master signals.
//   - Winner's m_rx_data, m_slave_valid, m_slave_ready follow the selected slave.
//   - All unselected outputs are driven 0. Outside BUSY all mux outputs are 0.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - Counter of width clog2(TIMEOUT_CYCLES) clears on BUSY entry.
//   - On the TIMEOUT_CYCLES-th consecutive BUSY cycle without trans_done: pulse bus_timeout, go to IDLE (grant drops next edge).
//  BUS_TIMEOUT_EN not defined: no counter; bus_timeout tied 0; TIMEOUT_CYCLES unused. BUSY may hold indefinitely.
// STRUCTURE
//  bus_pkg: state encoding (IDLE=2'd0, ARB=2'd1, BUSY=2'd2); clog2-derived index-width constants/functions.
//  Sub-module rr_arbiter: combinational round-robin picker.
//   - Inputs: req[NM], ptr. Outputs: winner index, any_req.
//   - Top level holds the FSM, the latches, the watchdog and the mux generate loops.
// TESTING  (NM=2, NS=3, SEL_W=2, TIMEOUT_CYCLES=16)
//  1. m_request=2'b01, m0 sel=2 -> arbiter_busy cycle k+1; m_grant=2'b01, bus_busy=1 at k+2.
//     s_master_valid[2] mirrors m0; s_*[0,1]=0. trans_done -> grant 0 next edge.
//  2. m_request=2'b11 straight after reset -> m0 granted first.
//     trans_done -> m_grant=2'b10 three edges later. Repeat -> m0 again (fairness).
//  3. m0 sel=3, m1 sel=0, both requesting -> sel_err pulse, no grant to m0; m1 then granted, routed to slave 0.
//  4. BUS_TIMEOUT_EN, grant held, no trans_done -> bus_timeout pulse on 16th BUSY cycle; m_grant=0 next edge.
//     Without the macro -> grant persists >100 cycles, bus_timeout=0.
//  5. sys_rst high mid-BUSY -> every output 0 at next edge. After release, m1-only request -> granted at k+2.
//  6. Winner drops m_request during BUSY, no trans_done -> grant released next edge; other pending master wins.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, index-width helper and bus bundle types
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    BUSY = 2'd2
  } bus_state_t;

  // Width of an index over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
    logic address;
    logic data;
    logic write_en;
    logic read_en;
  } m2s_t;

  typedef struct packed {
    logic data;
    logic valid;
    logic ready;
  } s2m_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searching upward from ptr+1
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);

  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    winner  = '0;
    any_req = |req;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect_nxm.sv
// rtl/bus_interconnect_nxm.sv - NxM round-robin interconnect; BUS_TIMEOUT_EN enables the BUSY watchdog
module bus_interconnect_nxm
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [NUM_MASTERS-1:0]       m_request,
  input  logic [NUM_MASTERS*SEL_W-1:0] m_slave_sel,
  input  logic                         trans_done,
  output logic [NUM_MASTERS-1:0]       m_grant,
  output logic                         arbiter_busy,
  output logic                         bus_busy,
  output logic                         sel_err,
  output logic                         bus_timeout,
  input  logic [NUM_MASTERS-1:0]       m_master_valid,
  input  logic [NUM_MASTERS-1:0]       m_master_ready,
  input  logic [NUM_MASTERS-1:0]       m_tx_address,
  input  logic [NUM_MASTERS-1:0]       m_tx_data,
  input  logic [NUM_MASTERS-1:0]       m_write_en,
  input  logic [NUM_MASTERS-1:0]       m_read_en,
  output logic [NUM_MASTERS-1:0]       m_rx_data,
  output logic [NUM_MASTERS-1:0]       m_slave_valid,
  output logic [NUM_MASTERS-1:0]       m_slave_ready,
  output logic [NUM_SLAVES-1:0]        s_master_valid,
  output logic [NUM_SLAVES-1:0]        s_master_ready,
  output logic [NUM_SLAVES-1:0]        s_rx_address,
  output logic [NUM_SLAVES-1:0]        s_rx_data,
  output logic [NUM_SLAVES-1:0]        s_write_en,
  output logic [NUM_SLAVES-1:0]        s_read_en,
  input  logic [NUM_SLAVES-1:0]        s_tx_data,
  input  logic [NUM_SLAVES-1:0]        s_slave_valid,
  input  logic [NUM_SLAVES-1:0]        s_slave_ready
);

  localparam int IDX_W = idx_w(NUM_MASTERS);

  if (NUM_MASTERS < 2)           $error("NUM_MASTERS must be at least 2");
  if ((1 << SEL_W) < NUM_SLAVES) $error("SEL_W too narrow for NUM_SLAVES");
  if (TIMEOUT_CYCLES < 2)        $error("TIMEOUT_CYCLES must be at least 2");

  bus_state_t       state, state_n;
  logic [IDX_W-1:0] rr_ptr, win_q, arb_win;
  logic [SEL_W-1:0] sel_q, arb_sel;
  logic             any_req, sel_valid, timeout_hit;

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_rr_arbiter (
    .req     (m_request),
    .ptr     (rr_ptr),
    .winner  (arb_win),
    .any_req (any_req)
  );

  assign arb_sel   = m_slave_sel[arb_win*SEL_W +: SEL_W];
  assign sel_valid = int'(arb_sel) < NUM_SLAVES;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = idx_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  // Counts BUSY cycles already completed; the last permitted cycle aborts.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state != BUSY) to_cnt <= '0;
    else                          to_cnt <= to_cnt + 1'b1;
  end
  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      rr_ptr <= IDX_W'(NUM_MASTERS - 1);
      win_q  <= '0;
      sel_q  <= '0;
    end else begin
      state <= state_n;
      if (state == ARB && any_req) begin
        win_q  <= arb_win;
        sel_q  <= arb_sel;
        rr_ptr <= arb_win;
      end
    end
  end

  always_comb begin
    state_n     = state;
    sel_err     = 1'b0;
    bus_timeout = 1'b0;
    case (state)
      IDLE: if (|m_request) state_n = ARB;
      ARB: begin
        if (!any_req) begin
          state_n = IDLE;
        end else if (sel_valid) begin
          state_n = BUSY;
        end else begin
          sel_err = 1'b1;
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (trans_done || !m_request[win_q]) begin
          state_n = IDLE;
        end else if (timeout_hit) begin
          bus_timeout = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign arbiter_busy = (state == ARB);
  assign bus_busy     = (state == BUSY);

  m2s_t m_bus [NUM_MASTERS];
  s2m_t s_bus [NUM_SLAVES];
  m2s_t win_m;
  s2m_t sel_s;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m_gather
    assign m_bus[i] = '{m_master_valid[i], m_master_ready[i], m_tx_address[i],
                        m_tx_data[i], m_write_en[i], m_read_en[i]};
  end

  for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_s_gather
    assign s_bus[j] = '{s_tx_data[j], s_slave_valid[j], s_slave_ready[j]};
  end

  always_comb begin
    win_m = '0;
    sel_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (win_q == IDX_W'(i)) win_m = m_bus[i];
    for (int j = 0; j < NUM_SLAVES; j++)
      if (sel_q == SEL_W'(j)) sel_s = s_bus[j];
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m_route
    s2m_t m_out;
    assign m_out            = (bus_busy && win_q == IDX_W'(i)) ? sel_s : '0;
    assign m_grant[i]       = bus_busy && win_q == IDX_W'(i);
    assign m_rx_data[i]     = m_out.data;
    assign m_slave_valid[i] = m_out.valid;
    assign m_slave_ready[i] = m_out.ready;
  end

  for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_s_route
    m2s_t s_out;
    assign s_out             = (bus_busy && sel_q == SEL_W'(j)) ? win_m : '0;
    assign s_master_valid[j] = s_out.valid;
    assign s_master_ready[j] = s_out.ready;
    assign s_rx_address[j]   = s_out.address;
    assign s_rx_data[j]      = s_out.data;
    assign s_write_en[j]     = s_out.write_en;
    assign s_read_en[j]      = s_out.read_en;
  end

endmodule

// File: tb/tb_bus_interconnect_nxm.sv
// tb/tb_bus_interconnect_nxm.sv - directed and randomized checks of the 2x3 interconnect against a behavioural model
module tb_bus_interconnect_nxm;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [NM-1:0] m_request;
  logic [NM*SW-1:0] m_slave_sel;
  logic          trans_done;
  logic [NM-1:0] m_grant;
  logic          arbiter_busy, bus_busy, sel_err, bus_timeout;
  logic [NM-1:0] m_master_valid, m_master_ready, m_tx_address, m_tx_data, m_write_en, m_read_en;
  logic [NM-1:0] m_rx_data, m_slave_valid, m_slave_ready;
  logic [NS-1:0] s_master_valid, s_master_ready, s_rx_address, s_rx_data, s_write_en, s_read_en;
  logic [NS-1:0] s_tx_data, s_slave_valid, s_slave_ready;

  int checks   = 0;
  int failures = 0;
  int last_win;

  always #5 sys_clk = ~sys_clk;

  bus_interconnect_nxm #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
    .trans_done(trans_done), .m_grant(m_grant), .arbiter_busy(arbiter_busy),
    .bus_busy(bus_busy), .sel_err(sel_err), .bus_timeout(bus_timeout),
    .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
    .m_tx_address(m_tx_address), .m_tx_data(m_tx_data), .m_write_en(m_write_en),
    .m_read_en(m_read_en), .m_rx_data(m_rx_data), .m_slave_valid(m_slave_valid),
    .m_slave_ready(m_slave_ready), .s_master_valid(s_master_valid),
    .s_master_ready(s_master_ready), .s_rx_address(s_rx_address), .s_rx_data(s_rx_data),
    .s_write_en(s_write_en), .s_read_en(s_read_en), .s_tx_data(s_tx_data),
    .s_slave_valid(s_slave_valid), .s_slave_ready(s_slave_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [29:0] all_outputs();
    return {m_grant, arbiter_busy, bus_busy, sel_err, bus_timeout, m_rx_data, m_slave_valid,
            m_slave_ready, s_master_valid, s_master_ready, s_rx_address, s_rx_data,
            s_write_en, s_read_en};
  endfunction

  // Round-robin rule: first requester after the last one served or rejected.
  function automatic int pick(input logic [NM-1:0] req, input int last);
    for (int k = 1; k <= NM; k++)
      if (req[(last + k) % NM]) return (last + k) % NM;
    return -1;
  endfunction

  task automatic do_reset;
    sys_rst = 1'b1; trans_done = 1'b0; m_request = '0;
    tick;
    check("reset_outputs", all_outputs(), '0);
    sys_rst  = 1'b0;
    last_win = NM - 1;
  endtask

  task automatic check_routing(input int w, input int s);
    logic [NS-1:0] e_mv, e_mr, e_ad, e_da, e_we, e_re;
    logic [NM-1:0] e_rx, e_sv, e_sr;
    m_master_valid = NM'($urandom); m_master_ready = NM'($urandom);
    m_tx_address   = NM'($urandom); m_tx_data      = NM'($urandom);
    m_write_en     = NM'($urandom); m_read_en      = NM'($urandom);
    s_tx_data      = NS'($urandom); s_slave_valid  = NS'($urandom);
    s_slave_ready  = NS'($urandom);
    #1;
    {e_mv, e_mr, e_ad, e_da, e_we, e_re} = '0;
    {e_rx, e_sv, e_sr} = '0;
    e_mv[s] = m_master_valid[w]; e_mr[s] = m_master_ready[w]; e_ad[s] = m_tx_address[w];
    e_da[s] = m_tx_data[w];      e_we[s] = m_write_en[w];     e_re[s] = m_read_en[w];
    e_rx[w] = s_tx_data[s];      e_sv[w] = s_slave_valid[s];  e_sr[w] = s_slave_ready[s];
    check("route_to_slave", {s_master_valid, s_master_ready, s_rx_address, s_rx_data, s_write_en, s_read_en},
          {e_mv, e_mr, e_ad, e_da, e_we, e_re});
    check("route_to_master", {m_rx_data, m_slave_valid, m_slave_ready}, {e_rx, e_sv, e_sr});
  endtask

  // From IDLE: request, one ARB cycle, then either a grant or a select error.
  task automatic arbitrate(input logic [NM-1:0] req, input logic [NM*SW-1:0] sel,
                           output int w, output int s, output bit granted);
    logic [3:0] e;
    logic [NM*SW-1:0] sv;
    m_request = req; m_slave_sel = sel; sv = sel;
    tick;
    check("arb_cycle", {arbiter_busy, bus_busy, m_grant}, 4'b1000);
    w = pick(req, last_win);
    s = int'(sv[w*SW +: SW]);
    last_win = w;
    if (s >= NS) begin
      check("sel_err_pulse", sel_err, 1'b1);
      tick;
      check("sel_err_no_grant", {arbiter_busy, bus_busy, m_grant, sel_err}, '0);
      granted = 1'b0;
    end else begin
      check("sel_ok", sel_err, 1'b0);
      tick;
      e = 4'b0100;
      e[w] = 1'b1;
      check("grant", {arbiter_busy, bus_busy, m_grant}, e);
      check_routing(w, s);
      granted = 1'b1;
    end
  endtask

  // mode 0: trans_done, 1: winner drops request, 2: both in the same cycle
  task automatic exit_busy(input int w, input int mode);
    if (mode != 1) trans_done = 1'b1;
    if (mode != 0) m_request[w] = 1'b0;
    tick;
    trans_done = 1'b0;
    check("exit_to_idle", {arbiter_busy, bus_busy, m_grant, bus_timeout}, '0);
  endtask

  initial begin
    int w, s, hold;
    bit granted, seen;
    logic [NM-1:0] g;
    sys_rst = 1'b1; trans_done = 1'b0; m_request = '0; m_slave_sel = '0;
    {m_master_valid, m_master_ready, m_tx_address, m_tx_data, m_write_en, m_read_en} = '0;
    {s_tx_data, s_slave_valid, s_slave_ready} = '0;
    tick;
    do_reset;

    // Fairness: both requesting, m0 then m1 then m0.
    for (int r = 0; r < 3; r++) begin
      arbitrate(2'b11, 4'b1001, w, s, granted);
      exit_busy(w, 0);
    end

    // m0 alone to slave 2; slave-side valid mirrors m0.
    m_request = '0;
    tick;
    arbitrate(2'b01, 4'b0010, w, s, granted);
    m_master_valid = 2'b01; #1;
    check("t1_valid_hi", s_master_valid, 3'b100);
    m_master_valid = 2'b00; #1;
    check("t1_valid_lo", s_master_valid, 3'b000);
    exit_busy(w, 0);

    // m0 selects nonexistent slave 3; m1 granted afterwards to slave 0.
    do_reset;
    arbitrate(2'b11, 4'b0011, w, s, granted);
    arbitrate(2'b11, 4'b0011, w, s, granted);
    exit_busy(w, 0);

    // Winner drops its request; the other pending master wins next.
    do_reset;
    arbitrate(2'b11, 4'b0000, w, s, granted);
    exit_busy(w, 1);
    arbitrate(m_request, 4'b0000, w, s, granted);
    exit_busy(w, 0);

    // Request withdrawn before the ARB edge: silent return to IDLE.
    m_request = 2'b01;
    tick;
    check("arb_withdraw_arb", arbiter_busy, 1'b1);
    m_request = 2'b00;
    tick;
    check("arb_withdraw_idle", {arbiter_busy, bus_busy, m_grant, sel_err}, '0);

    // Randomized transfers with mid-transfer select changes and mixed exits.
    for (int it = 0; it < 40; it++) begin
      arbitrate(NM'($urandom_range(1, 3)), (NM*SW)'($urandom), w, s, granted);
      if (granted) begin
        hold = $urandom_range(0, 5);
        g = '0;
        g[w] = 1'b1;
        for (int c = 0; c < hold; c++) begin
          m_slave_sel = (NM*SW)'($urandom);
          check_routing(w, s);
          tick;
          check("hold_grant", {bus_busy, m_grant}, {1'b1, g});
        end
        exit_busy(w, $urandom_range(0, 2));
      end
    end

    // Watchdog behaviour.
    m_request = '0;
    tick;
    arbitrate(2'b01, 4'b0000, w, s, granted);
`ifdef BUS_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      check("to_quiet", bus_timeout, 1'b0);
      tick;
    end
    check("to_pulse", {bus_timeout, m_grant}, 3'b101);
    tick;
    check("to_release", {bus_timeout, bus_busy, m_grant}, '0);
`else
    seen = 1'b0;
    for (int c = 0; c < 110; c++) begin
      seen |= bus_timeout;
      tick;
    end
    check("no_timeout_pulse", seen, 1'b0);
    check("grant_persists", {bus_busy, m_grant}, 3'b101);
    exit_busy(w, 0);
`endif

    // Reset mid-BUSY with all data inputs high, then m1 alone.
    m_request = '0;
    tick;
    arbitrate(2'b11, 4'b0101, w, s, granted);
    {m_master_valid, m_master_ready, m_tx_address, m_tx_data, m_write_en, m_read_en} = '1;
    {s_tx_data, s_slave_valid, s_slave_ready} = '1;
    sys_rst = 1'b1;
    tick;
    check("reset_mid_busy", all_outputs(), '0);
    sys_rst  = 1'b0;
    last_win = NM - 1;
    arbitrate(2'b10, 4'b0000, w, s, granted);
    exit_busy(w, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
